oppm_pulse_conditioner: RTL and testbench

Receive-side front end that sits directly upstream of the OPPM Decoder and feeds its `pulse` input. It takes the raw, asynchronous optical detector line and synchronises it to `clk`. It then measures the width of each high excursion, rejects glitches and stuck-high lines, and regenerates every accepted excursion as a clean pulse of exactly PULSE_CT clocks. This restores the pulse shape the Pulser/Modulator transmitted, so the Decoder sees ideal pulses.

---
 rtl/oppm_pulse_conditioner.sv | 145 ++++++++++++++
 tb/tb_oppm_pulse_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/oppm_pulse_conditioner.sv
// Synchronises the raw detector line, width-checks each high excursion and regenerates accepted ones as PULSE_CT-clock pulses.
// Optional OPPM_PC_STATS_EN adds saturating accept/reject counters with a synchronous clear.
module oppm_pulse_conditioner #(
  parameter int PULSE_CT    = 2,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic             pulse,
  output logic             pulse_err,
  output logic             busy
`ifdef OPPM_PC_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] rej_cnt
`endif
);

  localparam int WIN_HI = PULSE_CT + TOL;
  localparam int WIN_LO = (PULSE_CT - TOL < 1) ? 1 : PULSE_CT - TOL;
  localparam int WW     = $clog2(PULSE_CT + TOL + 2);
  localparam int EW     = $clog2(PULSE_CT + 1);

  localparam logic [WW-1:0] HI_W  = WW'(WIN_HI);
  localparam logic [WW-1:0] LO_W  = WW'(WIN_LO);
  localparam logic [WW-1:0] SAT_W = WW'(WIN_HI + 1);
  localparam logic [EW-1:0] LOAD_E = EW'(PULSE_CT);

  if (PULSE_CT < 1 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_param
    $error("oppm_pulse_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WW-1:0]          w_q, w_d;
  logic [EW-1:0]          e_q, e_d;
  logic                   err_q, err_d;
  logic                   s;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      w_q     <= '0;
      e_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      w_q     <= w_d;
      e_q     <= e_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx_in};
    s       = sync_q[SYNC_STAGES-1];
    state_d = state_q;
    w_d     = w_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = MEASURE;
          w_d     = WW'(1);
        end
      end
      MEASURE: begin
        if (s) begin
          // w never exceeds WIN_HI here, so the next count is at most SAT_W
          if (w_q >= HI_W) begin
            state_d = STUCK;
            w_d     = SAT_W;
            err_d   = 1'b1;
          end else begin
            w_d = w_q + 1'b1;
          end
        end else begin
          state_d = IDLE;
          w_d     = '0;
          if (w_q >= LO_W) accept = 1'b1;
          else             err_d  = 1'b1;
        end
      end
      STUCK: begin
        if (!s) begin
          state_d = IDLE;
          w_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        w_d     = '0;
      end
    endcase

    if (accept)          e_d = LOAD_E;
    else if (e_q != '0)  e_d = e_q - 1'b1;
    else                 e_d = '0;
  end

  assign pulse     = (e_q != '0);
  assign pulse_err = err_q;
  assign busy      = (state_q != IDLE) | pulse;

`ifdef OPPM_PC_STATS_EN
  logic [CNT_W-1:0] acc_q, acc_d, rej_q, rej_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones
  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    if (stats_clr) begin
      acc_d = '0;
      rej_d = '0;
    end else begin
      if (accept && (acc_q != '1)) acc_d = acc_q + 1'b1;
      if (err_q && (rej_q != '1))  rej_d = rej_q + 1'b1;
    end
  end

  assign acc_cnt = acc_q;
  assign rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_oppm_pulse_conditioner.sv
// Directed bench for oppm_pulse_conditioner: instance a uses PULSE_CT=2/TOL=1, instance b uses PULSE_CT=4/TOL=1.
// Counter checks run only when OPPM_PC_STATS_EN is defined (instance a uses CNT_W=2).
module tb_oppm_pulse_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx_in;
  logic pulse_a, err_a, busy_a;
  logic pulse_b, err_b, busy_b;
`ifdef OPPM_PC_STATS_EN
  logic        stats_clr;
  logic [1:0]  acc_a, rej_a;
  logic [15:0] acc_b, rej_b;
`endif

  oppm_pulse_conditioner #(.PULSE_CT(2), .TOL(1), .SYNC_STAGES(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .pulse(pulse_a), .pulse_err(err_a), .busy(busy_a)
`ifdef OPPM_PC_STATS_EN
    , .stats_clr(stats_clr), .acc_cnt(acc_a), .rej_cnt(rej_a)
`endif
  );

  oppm_pulse_conditioner #(.PULSE_CT(4), .TOL(1), .SYNC_STAGES(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .pulse(pulse_b), .pulse_err(err_b), .busy(busy_b)
`ifdef OPPM_PC_STATS_EN
    , .stats_clr(stats_clr), .acc_cnt(acc_b), .rej_cnt(rej_b)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running observations, sampled on the falling edge
  int a_rise = 0, a_hi = 0, a_err = 0, a_last_rise = 0, a_run = 0, a_last_run = 0;
  int b_hi = 0, b_err = 0;
  logic a_prev = 1'b0;

  always @(negedge clk) begin
    a_prev <= pulse_a;
    if (pulse_a) begin
      a_hi  <= a_hi + 1;
      a_run <= a_run + 1;
    end else if (a_run != 0) begin
      a_last_run <= a_run;
      a_run      <= 0;
    end
    if (pulse_a && !a_prev) begin
      a_rise      <= a_rise + 1;
      a_last_rise <= cyc;
    end
    if (err_a)   a_err <= a_err + 1;
    if (pulse_b) b_hi  <= b_hi + 1;
    if (err_b)   b_err <= b_err + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int w, input int gap);
    rx_in = 1'b1;
    repeat (w) step();
    rx_in = 1'b0;
    repeat (gap) step();
  endtask

  int r0, h0, e0, bh0, be0, t0;

  initial begin
    rst   = 1'b1;
    rx_in = 1'b0;
`ifdef OPPM_PC_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) step();
    chk("rst_pulse_a", pulse_a, 0);
    chk("rst_err_a",   err_a,   0);
    chk("rst_busy_a",  busy_a,  0);
    chk("rst_pulse_b", pulse_b, 0);
    chk("rst_busy_b",  busy_b,  0);
`ifdef OPPM_PC_STATS_EN
    chk("rst_acc", acc_a, 0);
    chk("rst_rej", rej_a, 0);
`endif
    rst = 1'b0;
    repeat (3) step();

    // Nominal 2-clock excursion: 2+2+1 clock latency, 2-cycle pulse
    r0 = a_rise; h0 = a_hi; e0 = a_err; t0 = cyc;
    burst(2, 12);
    chk("nom_rises",   a_rise - r0, 1);
    chk("nom_hi",      a_hi - h0,   2);
    chk("nom_err",     a_err - e0,  0);
    chk("nom_latency", a_last_rise - t0, 5);

    // Widths 1, 3, 4 with 3-clock gaps: two pulses, one reject
    r0 = a_rise; h0 = a_hi; e0 = a_err;
    burst(1, 3);
    burst(3, 3);
    burst(4, 3);
    repeat (10) step();
    chk("seq_rises", a_rise - r0, 2);
    chk("seq_hi",    a_hi - h0,   4);
    chk("seq_err",   a_err - e0,  1);
    chk("seq_idle",  busy_a,      0);

    // PULSE_CT=4 window is [3,5]: width 2 short, width 6 stuck
    bh0 = b_hi; be0 = b_err;
    burst(2, 12);
    chk("b_short_err", b_err - be0, 1);
    chk("b_short_hi",  b_hi - bh0,  0);
    bh0 = b_hi; be0 = b_err;
    burst(6, 12);
    chk("b_long_err", b_err - be0, 1);
    chk("b_long_hi",  b_hi - bh0,  0);
    chk("b_idle",     busy_b,      0);

    // Two 1-clock excursions, 1-clock gap: second accept reloads mid-emission
    r0 = a_rise; h0 = a_hi; e0 = a_err;
    burst(1, 1);
    burst(1, 10);
    chk("reload_rises", a_rise - r0, 1);
    chk("reload_hi",    a_hi - h0,   4);
    chk("reload_run",   a_last_run,  4);
    chk("reload_err",   a_err - e0,  0);

    // Two 3-clock excursions, 1-clock gap: both accepted, emitter lapses between
    r0 = a_rise; h0 = a_hi; e0 = a_err;
    burst(3, 1);
    burst(3, 10);
    chk("wide_pair_rises", a_rise - r0, 2);
    chk("wide_pair_hi",    a_hi - h0,   4);
    chk("wide_pair_err",   a_err - e0,  0);

    // Reset one clock into emission, rx held high across deassertion
    rx_in = 1'b1;
    step(); step();
    rx_in = 1'b0;
    step(); step(); step();
    chk("pre_rst_pulse", pulse_a, 1);
    rst   = 1'b1;
    rx_in = 1'b1;
    step();
    chk("mid_rst_pulse", pulse_a, 0);
    chk("mid_rst_busy",  busy_a,  0);
    chk("mid_rst_err",   err_a,   0);
    step();
    r0 = a_rise; e0 = a_err; be0 = b_err;
    rst = 1'b0;
    repeat (15) step();
    chk("stuck_busy", busy_a, 1);
    rx_in = 1'b0;
    repeat (10) step();
    chk("stuck_err_a",  a_err - e0,  1);
    chk("stuck_err_b",  b_err - be0, 1);
    chk("stuck_rises",  a_rise - r0, 0);
    chk("stuck_idle",   busy_a,      0);

`ifdef OPPM_PC_STATS_EN
    repeat (5) burst(2, 4);
    repeat (3) step();
    chk("acc_sat", acc_a, 3);
    chk("rej_one", rej_a, 1);
    // Clear lands on the same edge as an accept
    rx_in = 1'b1;
    step(); step();
    rx_in = 1'b0;
    step(); step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("clr_acc", acc_a, 0);
    chk("clr_rej", rej_a, 0);
    repeat (5) step();
    chk("clr_acc_hold", acc_a, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
